// File: rtl/cpu_ctrl_pkg.sv
// Shared opcode/funct values, select codes, FSM states and instruction classes
// for the register-file write-back controller.
package cpu_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_POP   = 6'h3E;

    localparam logic [5:0] FN_JR    = 6'h08;

    localparam logic [1:0] DST_RT = 2'd0;
    localparam logic [1:0] DST_RA = 2'd1;
    localparam logic [1:0] DST_SP = 2'd2;
    localparam logic [1:0] DST_RD = 2'd3;

    localparam logic [1:0] SRC_ALU = 2'd0;
    localparam logic [1:0] SRC_MEM = 2'd1;
    localparam logic [1:0] SRC_PC4 = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DECODE,
        ST_WAIT,
        ST_WRITE,
        ST_WRITE_SP
    } state_t;

    typedef enum logic [2:0] {
        CLS_RTYPE,
        CLS_IMM,
        CLS_LOAD,
        CLS_LINK,
        CLS_NOWB,
        CLS_POP,
        CLS_ILLEGAL
    } cls_t;

endpackage

// File: rtl/wb_decode.sv
// Combinational instruction classifier: opcode/funct to class, destination
// select and write-back source. STACK_OPS_EN makes opcode 0x3E (pop) legal.
module wb_decode
    import cpu_ctrl_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output cls_t       cls,
    output logic [1:0] dst,
    output logic [1:0] src
);

    always_comb begin
        cls = CLS_ILLEGAL;
        dst = DST_RT;
        src = SRC_ALU;
        case (opcode)
            OP_RTYPE: begin
                if (funct == FN_JR) begin
                    cls = CLS_NOWB;
                end else begin
                    cls = CLS_RTYPE;
                    dst = DST_RD;
                end
            end
            OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_LUI: begin
                cls = CLS_IMM;
            end
            OP_LW: begin
                cls = CLS_LOAD;
                src = SRC_MEM;
            end
            OP_JAL: begin
                cls = CLS_LINK;
                dst = DST_RA;
                src = SRC_PC4;
            end
            OP_SW, OP_BEQ, OP_BNE, OP_J: begin
                cls = CLS_NOWB;
            end
`ifdef STACK_OPS_EN
            // First half of pop loads rt; the $29 update is forced by the FSM.
            OP_POP: begin
                cls = CLS_POP;
                src = SRC_MEM;
            end
`endif
            default: begin
                cls = CLS_ILLEGAL;
            end
        endcase
    end

endmodule

// File: rtl/wb_ctrl.sv
// Multicycle write-back controller: accepts one instruction, waits for its
// result and strobes the register-file write. Optional pop support: STACK_OPS_EN.
module wb_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int TIMEOUT_W = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       issue_valid,
    output logic       issue_ready,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       result_valid,
    output logic [1:0] reg_dst_sel,
    output logic [1:0] wb_src_sel,
    output logic       reg_write,
    output logic       done,
    output logic       err
);

    // Last counter value before the wait would exceed 2^TIMEOUT_W-1 cycles.
    localparam logic [TIMEOUT_W-1:0] CNT_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

    state_t               state_reg, state_next;
    logic [5:0]           opcode_reg;
    logic [5:0]           funct_reg;
    logic [TIMEOUT_W-1:0] cnt_reg, cnt_next;

    cls_t       dec_cls;
    logic [1:0] dec_dst;
    logic [1:0] dec_src;

    wb_decode u_decode (
        .opcode (opcode_reg),
        .funct  (funct_reg),
        .cls    (dec_cls),
        .dst    (dec_dst),
        .src    (dec_src)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= ST_IDLE;
            cnt_reg    <= '0;
            opcode_reg <= '0;
            funct_reg  <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (state_reg == ST_IDLE && issue_valid) begin
                opcode_reg <= opcode;
                funct_reg  <= funct;
            end
        end
    end

    // Selects come from the latched instruction, so they stay stable until IDLE.
    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        issue_ready = 1'b0;
        reg_write   = 1'b0;
        done        = 1'b0;
        err         = 1'b0;
        reg_dst_sel = dec_dst;
        wb_src_sel  = dec_src;
        case (state_reg)
            ST_IDLE: begin
                issue_ready = 1'b1;
                reg_dst_sel = DST_RT;
                wb_src_sel  = SRC_ALU;
                cnt_next    = '0;
                if (issue_valid) begin
                    state_next = ST_DECODE;
                end
            end
            ST_DECODE: begin
                cnt_next = '0;
                case (dec_cls)
                    CLS_NOWB: begin
                        done       = 1'b1;
                        state_next = ST_IDLE;
                    end
                    CLS_ILLEGAL: begin
                        done       = 1'b1;
                        err        = 1'b1;
                        state_next = ST_IDLE;
                    end
                    default: begin
                        state_next = ST_WAIT;
                    end
                endcase
            end
            ST_WAIT: begin
                // A result on the final count still wins over the timeout.
                if (result_valid) begin
                    state_next = ST_WRITE;
                end else if (cnt_reg == CNT_LAST) begin
                    done       = 1'b1;
                    err        = 1'b1;
                    state_next = ST_IDLE;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            ST_WRITE: begin
                reg_write = 1'b1;
`ifdef STACK_OPS_EN
                if (dec_cls == CLS_POP) begin
                    state_next = ST_WRITE_SP;
                end else begin
                    done       = 1'b1;
                    state_next = ST_IDLE;
                end
`else
                done       = 1'b1;
                state_next = ST_IDLE;
`endif
            end
`ifdef STACK_OPS_EN
            ST_WRITE_SP: begin
                reg_write   = 1'b1;
                done        = 1'b1;
                reg_dst_sel = DST_SP;
                wb_src_sel  = SRC_ALU;
                state_next  = ST_IDLE;
            end
`endif
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_wb_ctrl.sv
// Directed bench for wb_ctrl with hand-computed expectations; pop cases are
// compiled in only when STACK_OPS_EN is defined.
module tb_wb_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       issue_valid;
    logic       issue_ready;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       result_valid;
    logic [1:0] reg_dst_sel;
    logic [1:0] wb_src_sel;
    logic       reg_write;
    logic       done;
    logic       err;

    int checks = 0;
    int passed = 0;
    int fails  = 0;
    int wr_count = 0;
    int wr_base;

    wb_ctrl #(.TIMEOUT_W(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .issue_valid  (issue_valid),
        .issue_ready  (issue_ready),
        .opcode       (opcode),
        .funct        (funct),
        .result_valid (result_valid),
        .reg_dst_sel  (reg_dst_sel),
        .wb_src_sel   (wb_src_sel),
        .reg_write    (reg_write),
        .done         (done),
        .err          (err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (reg_write === 1'b1) wr_count <= wr_count + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        reset        = 1'b1;
        issue_valid  = 1'b0;
        opcode       = 6'h00;
        funct        = 6'h00;
        result_valid = 1'b0;
        tick();
        reset = 1'b0;
        #1;
        $display("step reset");
        chk("rst_ready", issue_ready, 1);
        chk("rst_wr",    reg_write,   0);
        chk("rst_done",  done,        0);
        chk("rst_err",   err,         0);
        chk("rst_dst",   reg_dst_sel, 0);
        chk("rst_src",   wb_src_sel,  0);

        // result_valid in IDLE must not cause a write
        wr_base = wr_count;
        result_valid = 1'b1;
        tick();
        tick();
        result_valid = 1'b0;
        #1;
        $display("step idle result_valid");
        chk("idle_rv_nowrite", wr_count - wr_base, 0);
        chk("idle_rv_ready",   issue_ready,        1);

        // R-type add, result ready at WAIT entry
        wr_base = wr_count;
        issue_valid = 1'b1; opcode = 6'h00; funct = 6'h20; result_valid = 1'b1;
        tick();                                   // DECODE
        issue_valid = 1'b0; opcode = 6'h3F; funct = 6'h00;
        #1;
        $display("step add decode");
        chk("add_dec_dst",   reg_dst_sel, 3);
        chk("add_dec_src",   wb_src_sel,  0);
        chk("add_dec_ready", issue_ready, 0);
        chk("add_dec_done",  done,        0);
        tick();                                   // WAIT
        chk("add_wait_wr",   reg_write,   0);
        chk("add_wait_dst",  reg_dst_sel, 3);
        tick();                                   // WRITE
        $display("step add write");
        chk("add_wr",        reg_write,   1);
        chk("add_wr_done",   done,        1);
        chk("add_wr_err",    err,         0);
        chk("add_wr_dst",    reg_dst_sel, 3);
        result_valid = 1'b0;
        tick();                                   // IDLE
        chk("add_idle_ready", issue_ready, 1);
        chk("add_idle_dst",   reg_dst_sel, 0);
        chk("add_wr_count",   wr_count - wr_base, 1);

        // jal, result arrives on the third WAIT cycle
        wr_base = wr_count;
        issue_valid = 1'b1; opcode = 6'h03; funct = 6'h00;
        tick();                                   // DECODE
        issue_valid = 1'b0;
        #1;
        $display("step jal decode");
        chk("jal_dst", reg_dst_sel, 1);
        chk("jal_src", wb_src_sel,  2);
        tick();                                   // WAIT 1
        chk("jal_w1_wr", reg_write, 0);
        tick();                                   // WAIT 2
        chk("jal_w2_wr", reg_write, 0);
        tick();                                   // WAIT 3
        result_valid = 1'b1;
        #1;
        chk("jal_w3_wr", reg_write, 0);
        tick();                                   // WRITE
        result_valid = 1'b0;
        $display("step jal write");
        chk("jal_wr",      reg_write,   1);
        chk("jal_wr_dst",  reg_dst_sel, 1);
        chk("jal_wr_src",  wb_src_sel,  2);
        chk("jal_wr_done", done,        1);
        tick();                                   // IDLE
        chk("jal_wr_count", wr_count - wr_base, 1);

        // sw then lw back-to-back
        wr_base = wr_count;
        issue_valid = 1'b1; opcode = 6'h2B;
        tick();                                   // DECODE (sw)
        opcode = 6'h23;                           // held valid, ignored while busy
        #1;
        $display("step sw decode");
        chk("sw_done",  done,        1);
        chk("sw_err",   err,         0);
        chk("sw_wr",    reg_write,   0);
        chk("sw_ready", issue_ready, 0);
        tick();                                   // IDLE, lw accepted here
        chk("lw_accept_ready", issue_ready, 1);
        result_valid = 1'b1;
        tick();                                   // DECODE (lw)
        issue_valid = 1'b0;
        #1;
        chk("lw_dst", reg_dst_sel, 0);
        chk("lw_src", wb_src_sel,  1);
        tick();                                   // WAIT
        tick();                                   // WRITE
        $display("step lw write");
        chk("lw_wr",      reg_write,  1);
        chk("lw_wr_src",  wb_src_sel, 1);
        chk("lw_wr_done", done,       1);
        result_valid = 1'b0;
        tick();
        chk("swlw_wr_count", wr_count - wr_base, 1);

        // addi timeout: result never arrives
        wr_base = wr_count;
        issue_valid = 1'b1; opcode = 6'h08;
        tick();                                   // DECODE
        issue_valid = 1'b0;
        tick();                                   // WAIT 1
        for (int k = 1; k < 15; k++) begin
            chk("to_early_done", done, 0);
            tick();
        end
        $display("step timeout wait15");
        chk("to_done", done,      1);
        chk("to_err",  err,       1);
        chk("to_wr",   reg_write, 0);
        tick();
        chk("to_idle_ready", issue_ready,        1);
        chk("to_wr_count",   wr_count - wr_base, 0);

        // result on the final count still writes
        wr_base = wr_count;
        issue_valid = 1'b1; opcode = 6'h0D;
        tick();                                   // DECODE
        issue_valid = 1'b0;
        tick();                                   // WAIT 1
        for (int k = 1; k < 15; k++) tick();      // WAIT 15
        result_valid = 1'b1;
        #1;
        $display("step last-count result");
        chk("lastcnt_done", done, 0);
        chk("lastcnt_err",  err,  0);
        tick();                                   // WRITE
        result_valid = 1'b0;
        chk("lastcnt_wr",  reg_write, 1);
        chk("lastcnt_err2", err,      0);
        tick();
        chk("lastcnt_wr_count", wr_count - wr_base, 1);

        // illegal opcode 0x3F
        issue_valid = 1'b1; opcode = 6'h3F;
        tick();
        issue_valid = 1'b0;
        #1;
        $display("step illegal 3f");
        chk("ill_done", done,      1);
        chk("ill_err",  err,       1);
        chk("ill_wr",   reg_write, 0);
        tick();

        // jr: R-type opcode with funct 0x08 is a no-write
        issue_valid = 1'b1; opcode = 6'h00; funct = 6'h08;
        tick();
        issue_valid = 1'b0;
        #1;
        $display("step jr");
        chk("jr_done", done, 1);
        chk("jr_err",  err,  0);
        tick();

`ifdef STACK_OPS_EN
        // pop: two consecutive writes
        wr_base = wr_count;
        issue_valid = 1'b1; opcode = 6'h3E; funct = 6'h00; result_valid = 1'b1;
        tick();                                   // DECODE
        issue_valid = 1'b0;
        #1;
        chk("pop_dec_err", err, 0);
        tick();                                   // WAIT
        tick();                                   // WRITE
        $display("step pop write");
        chk("pop_w1",      reg_write,   1);
        chk("pop_w1_dst",  reg_dst_sel, 0);
        chk("pop_w1_src",  wb_src_sel,  1);
        chk("pop_w1_done", done,        0);
        tick();                                   // WRITE_SP
        chk("pop_w2",      reg_write,   1);
        chk("pop_w2_dst",  reg_dst_sel, 2);
        chk("pop_w2_src",  wb_src_sel,  0);
        chk("pop_w2_done", done,        1);
        result_valid = 1'b0;
        tick();
        chk("pop_wr_count", wr_count - wr_base, 2);

        // pop with reset during the first write
        wr_base = wr_count;
        issue_valid = 1'b1; opcode = 6'h3E; result_valid = 1'b1;
        tick();                                   // DECODE
        issue_valid = 1'b0;
        tick();                                   // WAIT
        tick();                                   // WRITE
        reset = 1'b1;
        tick();
        reset = 1'b0;
        result_valid = 1'b0;
        #1;
        $display("step pop reset");
        chk("popr_ready", issue_ready, 1);
        chk("popr_wr",    reg_write,   0);
        chk("popr_dst",   reg_dst_sel, 0);
        tick();
        chk("popr_wr_count", wr_count - wr_base, 1);
`else
        // without stack ops, 0x3E is illegal
        issue_valid = 1'b1; opcode = 6'h3E; funct = 6'h00;
        tick();
        issue_valid = 1'b0;
        #1;
        $display("step pop illegal");
        chk("pop_ill_done", done,        1);
        chk("pop_ill_err",  err,         1);
        chk("pop_ill_dst",  reg_dst_sel, 0);
        tick();
`endif

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/wb_ctrl.md
# wb_ctrl

Multicycle write-back controller for the CPU register file. It accepts one issued instruction at a time, classifies it from opcode/funct, and drives the destination-register mux select and write-back source select. It waits for the execution result and then pulses the register-file write enable. It sits between the instruction register/decoder and the register-file write port, and is the sole driver of the RegDest mux select.

## Interface
- Parameters:
- TIMEOUT_W, 4: width of the result-wait counter; a wait longer than 2^TIMEOUT_W−1 cycles aborts the instruction.
- Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- issue_valid  in  1  instruction presented
- issue_ready  out  1  controller can accept; high only in IDLE
- opcode  in  6  inst[31:26], sampled on accept
- funct  in  6  inst[5:0], sampled on accept
- result_valid  in  1  ALU/memory result available this cycle
- reg_dst_sel  out  2  0 = rt (inst[20:16]), 1 = $31, 2 = $29, 3 = rd (inst[15:11])
- wb_src_sel  out  2  0 = ALU, 1 = memory, 2 = PC+4
- reg_write  out  1  register-file write strobe, one cycle per write
- done  out  1  one-cycle pulse at instruction retirement
- err  out  1  one-cycle pulse with done: illegal opcode or timeout

## Operation
- States: IDLE, DECODE, WAIT, WRITE, WRITE_SP.
- IDLE: issue_ready=1. On issue_valid, latch opcode/funct and go to DECODE.
- DECODE: classify the instruction and register reg_dst_sel/wb_src_sel.
  - R-type (opcode 0, funct≠0x08): rd, ALU.
  - addi/andi/ori/slti/lui (0x08, 0x0C, 0x0D, 0x0A, 0x0F): rt, ALU.
  - lw (0x23): rt, mem.
  - jal (0x03): $31, PC+4.
  - jr, sw (0x2B), beq, bne, j: no-write.
  - Anything else: illegal.
- Transitions out of DECODE:
  - no-write → IDLE with done pulse.
  - illegal → IDLE with done and err pulses.
  - otherwise → WAIT.
- WAIT: counter increments each cycle.
  - result_valid=1 → WRITE.
  - Counter reaching max → IDLE with done and err pulses; no write.
- WRITE: reg_write=1 for one cycle.
  - Normal instruction: done=1 in the same cycle, then IDLE.
  - pop: go to WRITE_SP.
- WRITE_SP: reg_dst_sel=2, wb_src_sel=0, reg_write=1, done=1, then IDLE.
- reg_dst_sel/wb_src_sel are held stable from DECODE until return to IDLE. In IDLE they read 0.
- result_valid is ignored outside WAIT.
- issue_valid is ignored while issue_ready=0.

## Timing
- Reset: the edge with reset=1 forces IDLE.
  - Outputs afterwards: reg_write=0, done=0, err=0, reg_dst_sel=0, wb_src_sel=0, issue_ready=1.
  - Counter cleared.
  - An in-flight write is dropped, including during WRITE/WRITE_SP.
- No-write latency: accept edge → DECODE → done in the DECODE cycle. issue_ready returns 1 on the next cycle.
- Write latency: result_valid in WAIT cycle N → reg_write in cycle N+1 (registered).
- Minimum: accept, DECODE, WAIT (result_valid already high), WRITE → 4 cycles per instruction. pop takes 5.
- Back-to-back: a new accept is possible in the cycle after done.
- Timeout check: result_valid is checked before the counter. A result arriving on the final count still writes.
- Exactly one reg_write per normal write instruction. Exactly two for pop, in consecutive cycles.

## Configuration
- STACK_OPS_EN defined: opcode 0x3E (pop) is legal.
  - pop first writes rt from memory (reg_dst_sel=0, wb_src_sel=1) in WRITE.
  - It then writes $29 from the ALU (sp+4, computed in parallel) in WRITE_SP.
- STACK_OPS_EN undefined:
  - 0x3E is illegal.
  - WRITE_SP and its logic are removed.
  - reg_dst_sel never equals 2.

## Structure
- Package cpu_ctrl_pkg holds:
  - opcode/funct localparams.
  - State enum.
  - Dst-select codes (DST_RT, DST_RA, DST_SP, DST_RD).
  - Source codes (SRC_ALU, SRC_MEM, SRC_PC4).
  - Instruction-class enum (CLS_RTYPE, CLS_IMM, CLS_LOAD, CLS_LINK, CLS_NOWB, CLS_POP, CLS_ILLEGAL).
- Sub-module wb_decode: purely combinational, opcode/funct → class, dst code, src code. It is instantiated once in wb_ctrl, which holds the FSM, latches and timeout counter.

## Test plan
- Reset then idle: reset=1 one cycle → all outputs 0, issue_ready=1. result_valid=1 in IDLE → no reg_write.
- R-type add (opcode 0, funct 0x20), result_valid high from the WAIT entry:
  - reg_dst_sel=3, wb_src_sel=0 from DECODE.
  - Single reg_write with done 4 cycles after accept.
- jal (0x03), result_valid delayed 3 cycles: reg_dst_sel=1, wb_src_sel=2, reg_write exactly once, 3 cycles after the WAIT entry.
- sw (0x2B) then immediately lw (0x23):
  - sw → done in DECODE, no reg_write.
  - lw accepted the next cycle, then rt/mem write.
- Timeout with TIMEOUT_W=4 and result_valid held low: done and err on the 15th WAIT cycle, no reg_write. An illegal opcode 0x3F → err with done in DECODE.
- With STACK_OPS_EN, pop (0x3E):
  - Two consecutive reg_write cycles: first dst 0/src 1, then dst 2/src 0; done on the second.
  - Reset asserted during the first write → second write suppressed, IDLE.
